// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl: push-button entry of two BCD operands and an operator,
// handed to the ALU with a start/done handshake.
// Optional feature macro: DECREMENT_EN (adds btn_dec and decrement stepping).
module calc_entry_ctrl #(
    parameter int unsigned NDIG = 2,
    parameter int unsigned NOPS = 4,
    localparam int unsigned CW  = (NDIG > 1) ? $clog2(NDIG) : 1,
    localparam int unsigned W   = 4 * NDIG
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btn_inc,
    input  logic          btn_sel,
    input  logic          btn_enter,
`ifdef DECREMENT_EN
    input  logic          btn_dec,
`endif
    input  logic          alu_done,
    output logic [W-1:0]  operand_a,
    output logic [W-1:0]  operand_b,
    output logic [1:0]    op,
    output logic [CW-1:0] digit_sel,
    output logic [1:0]    state,
    output logic          alu_start,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_A   = 2'd0,
        S_B   = 2'd1,
        S_OP  = 2'd2,
        S_RUN = 2'd3
    } state_t;

    localparam int unsigned B_ENTER = 0;
    localparam int unsigned B_SEL   = 1;
    localparam int unsigned B_INC   = 2;
`ifdef DECREMENT_EN
    localparam int unsigned B_DEC   = 3;
    localparam int unsigned NBTN    = 4;
`else
    localparam int unsigned NBTN    = 3;
`endif

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync1;
    logic [NBTN-1:0] sync2;
    logic [NBTN-1:0] dly;
    logic [NBTN-1:0] edge_q;

    state_t          state_q;
    state_t          state_n;
    logic [W-1:0]    a_n;
    logic [W-1:0]    b_n;
    logic [W-1:0]    field;
    logic [1:0]      op_n;
    logic [CW-1:0]   sel_n;
    logic            start_n;
    logic            busy_n;

    logic            ev_enter;
    logic            ev_sel;
    logic            ev_inc;
`ifdef DECREMENT_EN
    logic            ev_dec;
`endif

`ifdef DECREMENT_EN
    assign btn_raw = {btn_dec, btn_inc, btn_sel, btn_enter};
`else
    assign btn_raw = {btn_inc, btn_sel, btn_enter};
`endif

    // Two-flop synchroniser, delay flop and registered rising-edge pulse per button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            dly    <= '0;
            edge_q <= '0;
        end else begin
            sync1  <= btn_raw;
            sync2  <= sync1;
            dly    <= sync2;
            edge_q <= sync2 & ~dly;
        end
    end

    assign ev_enter = edge_q[B_ENTER];
    assign ev_sel   = edge_q[B_SEL];
    assign ev_inc   = edge_q[B_INC];
`ifdef DECREMENT_EN
    assign ev_dec   = edge_q[B_DEC];
`endif

    function automatic logic [3:0] bcd_inc(input logic [3:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

`ifdef DECREMENT_EN
    function automatic logic [3:0] bcd_dec(input logic [3:0] d);
        return (d == 4'd0) ? 4'd9 : d - 4'd1;
    endfunction
`endif

    // State and datapath register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_A;
            operand_a <= '0;
            operand_b <= '0;
            op        <= '0;
            digit_sel <= '0;
            alu_start <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_n;
            operand_a <= a_n;
            operand_b <= b_n;
            op        <= op_n;
            digit_sel <= sel_n;
            alu_start <= start_n;
            busy      <= busy_n;
        end
    end

    // Next-state and next-value logic; if/else chain gives enter > sel > inc > dec
    always_comb begin
        state_n = state_q;
        a_n     = operand_a;
        b_n     = operand_b;
        op_n    = op;
        sel_n   = digit_sel;
        start_n = 1'b0;
        busy_n  = busy;
        field   = (state_q == S_B) ? operand_b : operand_a;

        case (state_q)
            S_A, S_B: begin
                if (ev_enter) begin
                    state_n = (state_q == S_A) ? S_B : S_OP;
                    sel_n   = '0;
                end else if (ev_sel) begin
                    sel_n = (digit_sel == CW'(NDIG - 1)) ? '0 : digit_sel + CW'(1);
                end else if (ev_inc) begin
                    for (int unsigned i = 0; i < NDIG; i++) begin
                        if (digit_sel == CW'(i)) field[4*i +: 4] = bcd_inc(field[4*i +: 4]);
                    end
`ifdef DECREMENT_EN
                end else if (ev_dec) begin
                    for (int unsigned i = 0; i < NDIG; i++) begin
                        if (digit_sel == CW'(i)) field[4*i +: 4] = bcd_dec(field[4*i +: 4]);
                    end
`endif
                end
                if (state_q == S_A) a_n = field;
                else                b_n = field;
            end
            S_OP: begin
                if (ev_enter) begin
                    state_n = S_RUN;
                    start_n = 1'b1;
                    busy_n  = 1'b1;
                end else if (ev_inc && !ev_sel) begin
                    op_n = (op == 2'(NOPS - 1)) ? 2'd0 : op + 2'd1;
`ifdef DECREMENT_EN
                end else if (ev_dec && !ev_sel) begin
                    op_n = (op == 2'd0) ? 2'(NOPS - 1) : op - 2'd1;
`endif
                end
            end
            S_RUN: begin
                // done is only honoured once the start pulse has been seen
                if (!alu_start && alu_done) begin
                    state_n = S_A;
                    a_n     = '0;
                    b_n     = '0;
                    op_n    = '0;
                    sel_n   = '0;
                    busy_n  = 1'b0;
                end
            end
            default: state_n = S_A;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Bench for calc_entry_ctrl (NDIG=2, NOPS=4): directed button sequences, a
// cycle-level behavioural model checked every cycle, plus literal expectations.
// Build with +define+DECREMENT_EN to exercise the decrement feature.
module tb_calc_entry_ctrl;

    localparam int NDIG = 2;
    localparam int NOPS = 4;
    localparam int W    = 4 * NDIG;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn_inc = 1'b0;
    logic          btn_sel = 1'b0;
    logic          btn_enter = 1'b0;
`ifdef DECREMENT_EN
    logic          btn_dec = 1'b0;
`endif
    logic          alu_done = 1'b0;
    logic [W-1:0]  operand_a;
    logic [W-1:0]  operand_b;
    logic [1:0]    op;
    logic [0:0]    digit_sel;
    logic [1:0]    state;
    logic          alu_start;
    logic          busy;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int start_cnt = 0;

    calc_entry_ctrl #(.NDIG(NDIG), .NOPS(NOPS)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_inc   (btn_inc),
        .btn_sel   (btn_sel),
        .btn_enter (btn_enter),
`ifdef DECREMENT_EN
        .btn_dec   (btn_dec),
`endif
        .alu_done  (alu_done),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .op        (op),
        .digit_sel (digit_sel),
        .state     (state),
        .alu_start (alu_start),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int due; int kind; } ev_t;   // kind: 0 enter 1 sel 2 inc 3 dec
    ev_t pend[$];
    int  m_st, m_op, m_cur;
    int  m_a[NDIG];
    int  m_b[NDIG];
    bit  m_start, m_busy;
    bit  rst_prev = 1'b1;
    bit  done_prev = 1'b0;
    bit  pe, ps, pi, pd;

    task automatic m_reset();
        m_st = 0; m_op = 0; m_cur = 0; m_start = 0; m_busy = 0;
        for (int i = 0; i < NDIG; i++) begin m_a[i] = 0; m_b[i] = 0; end
    endtask

    // Advance the model across one clock edge numbered p
    task automatic m_step(input int p);
        bit e, s, u, d, st_new;
        ev_t keep[$];
        e = 0; s = 0; u = 0; d = 0; st_new = 0;
        foreach (pend[k]) begin
            if (pend[k].due == p) begin
                case (pend[k].kind)
                    0: e = 1;
                    1: s = 1;
                    2: u = 1;
                    default: d = 1;
                endcase
            end else keep.push_back(pend[k]);
        end
        pend = keep;
        if (m_st == 0 || m_st == 1) begin
            if (e) begin m_st++; m_cur = 0; end
            else if (s) m_cur = (m_cur + 1) % NDIG;
            else if (u || d) begin
                if (m_st == 0) m_a[m_cur] = (m_a[m_cur] + (u ? 1 : 9)) % 10;
                else           m_b[m_cur] = (m_b[m_cur] + (u ? 1 : 9)) % 10;
            end
        end else if (m_st == 2) begin
            if (e) begin m_st = 3; st_new = 1; end
            else if (s) ;
            else if (u) m_op = (m_op + 1) % NOPS;
            else if (d) m_op = (m_op + NOPS - 1) % NOPS;
        end else begin
            if (!m_start && done_prev) begin
                m_st = 0; m_op = 0; m_cur = 0;
                for (int i = 0; i < NDIG; i++) begin m_a[i] = 0; m_b[i] = 0; end
            end
        end
        m_start = st_new;
        m_busy  = (m_st == 3);
    endtask

    // Model update and full output comparison every cycle, away from the active edge
    always @(negedge clk) begin
        logic [W-1:0] ea, eb;
        if (rst) begin
            m_reset();
            pend.delete();
        end else if (!rst_prev) begin
            m_step(cyc);
        end
        if (!rst) begin
            if (btn_enter && !pe) pend.push_back('{cyc + 4, 0});
            if (btn_sel   && !ps) pend.push_back('{cyc + 4, 1});
            if (btn_inc   && !pi) pend.push_back('{cyc + 4, 2});
`ifdef DECREMENT_EN
            if (btn_dec   && !pd) pend.push_back('{cyc + 4, 3});
`endif
        end
        pe = rst ? 1'b0 : btn_enter;
        ps = rst ? 1'b0 : btn_sel;
        pi = rst ? 1'b0 : btn_inc;
`ifdef DECREMENT_EN
        pd = rst ? 1'b0 : btn_dec;
`else
        pd = 1'b0;
`endif
        done_prev = alu_done;
        rst_prev  = rst;
        for (int i = 0; i < NDIG; i++) begin
            ea[4*i +: 4] = 4'(m_a[i]);
            eb[4*i +: 4] = 4'(m_b[i]);
        end
        check("cyc operand_a", 32'(operand_a), 32'(ea));
        check("cyc operand_b", 32'(operand_b), 32'(eb));
        check("cyc op",        32'(op),        32'(m_op));
        check("cyc digit_sel", 32'(digit_sel), 32'(m_cur));
        check("cyc state",     32'(state),     32'(m_st));
        check("cyc alu_start", 32'(alu_start), 32'(m_start));
        check("cyc busy",      32'(busy),      32'(m_busy));
        if (alu_start === 1'b1) start_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // mask bits: 0 enter, 1 sel, 2 inc, 3 dec
    task automatic press(input logic [3:0] m);
        btn_enter = m[0]; btn_sel = m[1]; btn_inc = m[2];
`ifdef DECREMENT_EN
        btn_dec = m[3];
`endif
        step(2);
        btn_enter = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
`ifdef DECREMENT_EN
        btn_dec = 1'b0;
`endif
        step(3);
    endtask

    localparam logic [3:0] P_ENTER = 4'b0001;
    localparam logic [3:0] P_SEL   = 4'b0010;
    localparam logic [3:0] P_INC   = 4'b0100;
    localparam logic [3:0] P_DEC   = 4'b1000;

    initial begin
        int s0;
        #1;
        check("reset state",     32'(state),     32'd0);
        check("reset operand_a", 32'(operand_a), 32'd0);
        check("reset busy",      32'(busy),      32'd0);
        step(2);
        rst = 1'b0;
        step(2);

        // 12 increments on digit 0; the last one timed against the 4-cycle latency
        for (int i = 0; i < 11; i++) press(P_INC);
        check("11 inc", 32'(operand_a), 32'h01);
        btn_inc = 1'b1;
        step(3);
        check("latency 3clk unchanged", 32'(operand_a), 32'h01);
        step(1);
        check("latency 4clk changed", 32'(operand_a), 32'h02);
        btn_inc = 1'b0;
        step(3);

        // cursor to digit 1, three increments, cursor wraps back
        press(P_SEL);
        check("sel to 1", 32'(digit_sel), 32'd1);
        for (int i = 0; i < 3; i++) press(P_INC);
        check("digit1 x3", 32'(operand_a), 32'h32);
        check("digit_sel 1", 32'(digit_sel), 32'd1);
        press(P_SEL);
        check("sel wrap", 32'(digit_sel), 32'd0);

        // asynchronous reset mid-sequence
        press(P_ENTER);
        check("enter to S_B", 32'(state), 32'd1);
        press(P_INC);
        check("operand_b inc", 32'(operand_b), 32'h01);
        rst = 1'b1;
        #1;
        check("async rst state", 32'(state),     32'd0);
        check("async rst a",     32'(operand_a), 32'd0);
        check("async rst b",     32'(operand_b), 32'd0);
        check("async rst sel",   32'(digit_sel), 32'd0);
        step(1);
        rst = 1'b0;
        step(2);

        // full entry and ALU handshake
        press(P_ENTER);
        press(P_INC);
        press(P_ENTER);
        for (int i = 0; i < 5; i++) press(P_INC);
        check("op after 5 inc", 32'(op), 32'd1);
        check("state S_OP", 32'(state), 32'd2);
        s0 = start_cnt;
        press(P_ENTER);
        check("state S_RUN", 32'(state), 32'd3);
        check("busy in run", 32'(busy), 32'd1);
        check("start pulse cycles", 32'(start_cnt - s0), 32'd1);
        press(P_INC);
        check("op held in run", 32'(op), 32'd1);
        check("b held in run", 32'(operand_b), 32'h01);
        step(10);
        alu_done = 1'b1;
        step(1);
        alu_done = 1'b0;
        step(2);
        check("done state", 32'(state), 32'd0);
        check("done b cleared", 32'(operand_b), 32'd0);
        check("done op cleared", 32'(op), 32'd0);
        check("done busy", 32'(busy), 32'd0);

        // simultaneous enter and inc: enter wins, inc dropped
        press(P_INC);
        press(P_ENTER | P_INC);
        check("prio state", 32'(state), 32'd1);
        check("prio operand_a", 32'(operand_a), 32'h01);
        press(P_ENTER);
`ifdef DECREMENT_EN
        press(P_DEC);
        check("op dec wrap", 32'(op), 32'd3);
`endif

        // reset while the start pulse is high; later done ignored
        btn_enter = 1'b1;
        step(4);
        check("start high", 32'(alu_start), 32'd1);
        btn_enter = 1'b0;
        rst = 1'b1;
        #1;
        check("rst run state", 32'(state), 32'd0);
        check("rst run start", 32'(alu_start), 32'd0);
        check("rst run busy", 32'(busy), 32'd0);
        step(1);
        rst = 1'b0;
        step(2);
        alu_done = 1'b1;
        step(1);
        alu_done = 1'b0;
        step(3);
        check("late done ignored", 32'(state), 32'd0);
`ifdef DECREMENT_EN
        press(P_DEC);
        check("digit dec wrap", 32'(operand_a), 32'h09);
`endif
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
